// File: rtl/lfsr_checker.sv
// LFSR stream checker: seeds from the received words, locks after LOCK_CNT
// correct predictions, then flags and counts deviations. Optional word counter: LFSR_CHECKER_WORD_CNT_EN.
module lfsr_checker #(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] TAPS     = 4'b1100,
  parameter int               LOCK_CNT = 4,
  parameter int               LOSS_CNT = 3,
  parameter int               CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
`ifdef LFSR_CHECKER_WORD_CNT_EN
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] word_cnt
`else
  output logic [CNT_W-1:0] err_cnt
`endif
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);

  typedef enum logic [1:0] {SEARCH, SYNC, LOCKED} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] expected_reg, expected_next;
  logic [MW-1:0]    match_reg, match_next;
  logic [LW-1:0]    miss_reg, miss_next;
  logic             err_reg, err_next;
  logic             locked_reg;
  logic [CNT_W-1:0] err_cnt_reg, err_cnt_next;

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  always_comb begin
    state_next    = state_reg;
    expected_next = expected_reg;
    match_next    = match_reg;
    miss_next     = miss_reg;
    err_next      = 1'b0;
    if (in_valid) begin
      case (state_reg)
        SEARCH: begin
          // all-zero is the LFSR lockup word and can never seed a sequence
          if (in_data != '0) begin
            expected_next = lfsr_next(in_data);
            match_next    = '0;
            state_next    = SYNC;
          end
        end
        SYNC: begin
          if (in_data == expected_reg) begin
            expected_next = lfsr_next(expected_reg);
            if (match_reg == MW'(LOCK_CNT - 1)) begin
              state_next = LOCKED;
              match_next = '0;
              miss_next  = '0;
            end else begin
              match_next = match_reg + 1'b1;
            end
          end else if (in_data != '0) begin
            expected_next = lfsr_next(in_data);
            match_next    = '0;
          end else begin
            match_next = '0;
            state_next = SEARCH;
          end
        end
        LOCKED: begin
          // once locked the prediction free-runs so errors cannot corrupt it
          expected_next = lfsr_next(expected_reg);
          if (in_data == expected_reg) begin
            miss_next = '0;
          end else begin
            err_next = 1'b1;
            if (miss_reg == LW'(LOSS_CNT - 1)) begin
              miss_next  = '0;
              state_next = SEARCH;
            end else begin
              miss_next = miss_reg + 1'b1;
            end
          end
        end
        default: state_next = SEARCH;
      endcase
    end
  end

  always_comb begin
    err_cnt_next = err_cnt_reg;
    if (clr_cnt)
      err_cnt_next = '0;
    else if (err_next && err_cnt_reg != '1)
      err_cnt_next = err_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= SEARCH;
      expected_reg <= '0;
      match_reg    <= '0;
      miss_reg     <= '0;
      err_reg      <= 1'b0;
      locked_reg   <= 1'b0;
      err_cnt_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      expected_reg <= expected_next;
      match_reg    <= match_next;
      miss_reg     <= miss_next;
      err_reg      <= err_next;
      locked_reg   <= (state_next == LOCKED);
      err_cnt_reg  <= err_cnt_next;
    end
  end

`ifdef LFSR_CHECKER_WORD_CNT_EN
  logic [CNT_W-1:0] word_cnt_reg;

  // BER denominator: every word judged while locked, good or bad
  always_ff @(posedge clk) begin
    if (rst || clr_cnt)
      word_cnt_reg <= '0;
    else if (in_valid && state_reg == LOCKED && word_cnt_reg != '1)
      word_cnt_reg <= word_cnt_reg + 1'b1;
  end

  assign word_cnt = word_cnt_reg;
`endif

  assign locked  = locked_reg;
  assign err     = err_reg;
  assign err_cnt = err_cnt_reg;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: default instance plus a CNT_W=4 / large LOSS_CNT
// instance for saturation checks.
module tb_lfsr_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        v1, c1, v2, c2;
  logic [3:0]  d1, d2;
  logic        locked1, err1, locked2, err2;
  logic [15:0] cnt1;
  logic [3:0]  cnt2;
`ifdef LFSR_CHECKER_WORD_CNT_EN
  logic [15:0] wcnt1;
  logic [3:0]  wcnt2;
`endif

  lfsr_checker dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_data(d1), .clr_cnt(c1),
    .locked(locked1), .err(err1),
`ifdef LFSR_CHECKER_WORD_CNT_EN
    .err_cnt(cnt1), .word_cnt(wcnt1)
`else
    .err_cnt(cnt1)
`endif
  );

  lfsr_checker #(.CNT_W(4), .LOSS_CNT(31)) dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_data(d2), .clr_cnt(c2),
    .locked(locked2), .err(err2),
`ifdef LFSR_CHECKER_WORD_CNT_EN
    .err_cnt(cnt2), .word_cnt(wcnt2)
`else
    .err_cnt(cnt2)
`endif
  );

  int checks = 0;
  int failures = 0;
  logic [3:0] exp_w;

  function automatic logic [3:0] nxt(input logic [3:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step1(input logic v, input logic [3:0] d, input logic c);
    v1 = v; d1 = d; c1 = c; v2 = 1'b0; d2 = 4'h0; c2 = 1'b0;
    @(posedge clk); #1;
    $display("dut1 valid=%0b data=%h clr=%0b -> locked=%0b err=%0b err_cnt=%0d", v, d, c, locked1, err1, cnt1);
  endtask

  task automatic step2(input logic v, input logic [3:0] d, input logic c);
    v2 = v; d2 = d; c2 = c; v1 = 1'b0; d1 = 4'h0; c1 = 1'b0;
    @(posedge clk); #1;
    $display("dut2 valid=%0b data=%h clr=%0b -> locked=%0b err=%0b err_cnt=%0d", v, d, c, locked2, err2, cnt2);
  endtask

  initial begin
    rst = 1'b1; v1 = 0; d1 = 0; c1 = 0; v2 = 0; d2 = 0; c2 = 0;
    // reset state
    step1(1'b1, 4'h1, 1'b0);
    step1(1'b0, 4'h0, 1'b0);
    chk("rst_locked", locked1, 0);
    chk("rst_err", err1, 0);
    chk("rst_cnt", cnt1, 0);
    chk("rst_locked2", locked2, 0);
    rst = 1'b0;

    // 1: lock after seed + 4 matches
    step1(1, 4'h1, 0); chk("t1_w1_locked", locked1, 0);
    step1(1, 4'h2, 0); chk("t1_w2_locked", locked1, 0);
    step1(1, 4'h4, 0); chk("t1_w3_locked", locked1, 0);
    step1(1, 4'h9, 0); chk("t1_w4_locked", locked1, 0);
    step1(1, 4'h3, 0); chk("t1_w5_locked", locked1, 1);
    chk("t1_err", err1, 0);
    chk("t1_cnt", cnt1, 0);

    // 2: single error, prediction continues
    step1(1, 4'h0, 0);
    chk("t2_err", err1, 1); chk("t2_cnt", cnt1, 1); chk("t2_locked", locked1, 1);
    step1(1, 4'hD, 0);
    chk("t2_err_one_cycle", err1, 0); chk("t2_locked_b", locked1, 1);
    step1(1, 4'hA, 0);
    chk("t2_err_c", err1, 0); chk("t2_cnt_c", cnt1, 1);

    // 3: clear, 3 consecutive errors drop lock, relock from 1000
    step1(1, 4'h5, 1);
    chk("t3_clr_cnt", cnt1, 0); chk("t3_clr_err", err1, 0);
    step1(1, 4'h0, 0); chk("t3_e1_err", err1, 1); chk("t3_e1_locked", locked1, 1);
    step1(1, 4'h0, 0); chk("t3_e2_err", err1, 1); chk("t3_e2_locked", locked1, 1);
    step1(1, 4'h0, 0); chk("t3_e3_err", err1, 1); chk("t3_e3_locked", locked1, 0);
    chk("t3_cnt", cnt1, 3);
    step1(1, 4'h8, 0); chk("t3_r1_locked", locked1, 0); chk("t3_r1_err", err1, 0);
    step1(1, 4'h1, 0); chk("t3_r2_locked", locked1, 0);
    step1(1, 4'h2, 0); chk("t3_r3_locked", locked1, 0);
    step1(1, 4'h4, 0); chk("t3_r4_locked", locked1, 0);
    step1(1, 4'h9, 0); chk("t3_r5_locked", locked1, 1); chk("t3_r5_err", err1, 0);

    // 6b: accumulate 7 isolated errors, then reset while locked
    exp_w = 4'h3;
    step1(1, exp_w, 1); exp_w = nxt(exp_w);
    chk("t6_clr", cnt1, 0);
    for (int i = 0; i < 7; i++) begin
      step1(1, exp_w ^ 4'hF, 0); exp_w = nxt(exp_w);
      chk("t6_iso_err", err1, 1);
      step1(1, exp_w, 0); exp_w = nxt(exp_w);
      chk("t6_iso_ok", err1, 0);
    end
    chk("t6_cnt7", cnt1, 7); chk("t6_locked_pre", locked1, 1);
    rst = 1'b1;
    step1(1, exp_w ^ 4'hF, 0);
    rst = 1'b0;
    chk("t6_rst_locked", locked1, 0); chk("t6_rst_cnt", cnt1, 0); chk("t6_rst_err", err1, 0);

    // 6a: reset during SYNC after 2 matches; 0000 ignored; next word is a seed
    step1(1, 4'h1, 0); step1(1, 4'h2, 0); step1(1, 4'h4, 0);
    rst = 1'b1; step1(0, 4'h0, 0); rst = 1'b0;
    chk("t6a_rst_locked", locked1, 0);
    step1(1, 4'h0, 0); chk("t6a_zero_locked", locked1, 0);
    step1(1, 4'h9, 0); chk("t6a_seed_locked", locked1, 0);
    step1(1, 4'h3, 0); chk("t6a_m1_locked", locked1, 0);
    step1(1, 4'h6, 0); chk("t6a_m2_locked", locked1, 0);
    step1(1, 4'hD, 0); chk("t6a_m3_locked", locked1, 0);
    step1(1, 4'hA, 0); chk("t6a_m4_locked", locked1, 1);
    chk("t6a_err", err1, 0);

    // 4: scenario 1 with idle gaps carrying garbage data
    rst = 1'b1; step1(0, 4'h0, 0); rst = 1'b0;
    step1(1, 4'h1, 0);
    step1(0, 4'h7, 0); chk("t4_gap1_err", err1, 0);
    step1(1, 4'h2, 0);
    step1(0, 4'hF, 0); step1(0, 4'h0, 0); chk("t4_gap2_locked", locked1, 0);
    step1(1, 4'h4, 0);
    step1(1, 4'h9, 0);
    step1(0, 4'h5, 0); chk("t4_gap3_locked", locked1, 0);
    step1(1, 4'h3, 0); chk("t4_locked", locked1, 1);
    step1(0, 4'h0, 0); chk("t4_gap4_err", err1, 0); chk("t4_gap4_locked", locked1, 1);
    step1(1, 4'h6, 0); chk("t4_next_err", err1, 0); chk("t4_cnt", cnt1, 0);

    // 5: CNT_W=4 saturation, then clear colliding with an error
    step2(1, 4'h1, 0); step2(1, 4'h2, 0); step2(1, 4'h4, 0); step2(1, 4'h9, 0);
    step2(1, 4'h3, 0); chk("t5_locked", locked2, 1);
    exp_w = 4'h6;
    for (int i = 0; i < 20; i++) begin
      step2(1, exp_w ^ 4'h5, 0); exp_w = nxt(exp_w);
      chk("t5_err", err2, 1);
      chk("t5_cnt", cnt2, (i + 1 > 15) ? 15 : i + 1);
      step2(1, exp_w, 0); exp_w = nxt(exp_w);
      chk("t5_locked_hold", locked2, 1);
    end
    step2(1, exp_w ^ 4'h5, 1);
    chk("t5_clr_err", err2, 1); chk("t5_clr_cnt", cnt2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
